anim_frame_sequencer: RTL and testbench
=======================================

Name: anim_frame_sequencer

Overview:
- Consumes the periodic pulse from the upstream frame-rate counter stage, one pulse per counter wrap.
- Steps the player sprite through animation frames for IDLE, WALK and JUMP/LAND.
- Outputs the frame index, facing bit and sprite ROM word address to the downstream sprite fetch/draw logic.

Parameters:
- TICKS_PER_FRAME, 4: tick_in pulses per animation frame advance (>=1).
- IDLE_FRAMES, 2: frames in idle loop (1..8).
- WALK_FRAMES, 6: frames in walk loop (2..8).
- JUMP_FRAMES, 4: frames in one-shot jump sequence (1..8).
- LAND_HOLD, 2: animation frames spent in LAND before release (>=1).
- FRAME_WORDS, 1024: ROM words per sprite frame.
- ADDR_W, 16: sprite_addr width.

Ports:
- Clk  in  1  system clock, all logic rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- tick_in  in  1  one-cycle pulse from upstream counter at terminal count.
- move_left  in  1  level, player holding left.
- move_right  in  1  level, player holding right.
- jump_req  in  1  level or pulse; sampled every cycle.
- anim_state  out  2  current state code (IDLE=0, WALK=1, JUMP=2, LAND=3).
- frame_idx  out  3  frame within current sequence.
- facing_left  out  1  1 = sprite mirrored.
- sprite_addr  out  ADDR_W  base(anim_state) + frame_idx*FRAME_WORDS; combinational from registered state.
- jump_busy  out  1  high in JUMP or LAND.
- jump_done  out  1  one-cycle pulse on the LAND->IDLE/WALK transition.

Behaviour:
- Reset values (async, immediate): anim_state=IDLE, frame_idx=0, facing_left=0, prescaler=0, jump_done=0. jump_busy=0 and sprite_addr=IDLE_BASE follow from the registered state.
- Reset mid-jump aborts the sequence; jump_done does not pulse.
- Move decode: walk = move_left XOR move_right. Both held, or neither held, means no walk.
- Prescaler counts tick_in pulses 0..TICKS_PER_FRAME-1. A frame advance fires on the tick_in where prescaler == TICKS_PER_FRAME-1; the prescaler then wraps to 0.
- Any state change clears frame_idx and the prescaler on the same edge.
- Transitions, registered, one-cycle latency from input:
  - IDLE: jump_req -> JUMP; else walk -> WALK.
  - WALK: jump_req -> JUMP; else !walk -> IDLE.
  - JUMP: on an advance with frame_idx == JUMP_FRAMES-1 -> LAND. jump_req and movement are ignored; no buffering.
  - LAND: after LAND_HOLD advances -> WALK if walk else IDLE, and pulse jump_done that cycle. frame_idx holds 0 in LAND.
- Priority: jump_req beats walk in IDLE/WALK. Jump is non-interruptible except by Reset.
- frame_idx in IDLE/WALK wraps to 0 after the count-1 frame. In JUMP it never wraps.
- Facing: facing_left <= move_left when walk, updated only in IDLE/WALK. It holds through JUMP/LAND and when both or neither direction is held.
- Simultaneous events:
  - tick_in on the same cycle as a state change: the state change wins and the advance is discarded.
  - tick_in while prescaler is mid-count keeps counting across idle cycles.
- Arithmetic: sprite_addr is computed at ADDR_W width and truncated modulo 2^ADDR_W. The package bases must fit; no overflow check in RTL.

Optional Feature:
- ANIM_PINGPONG_EN defined: WALK frames play ping-pong (0,1,..,N-1,N-2,..,1,0,1..) using a direction flop. The flop resets to up and is reset to up on WALK entry.
- ANIM_PINGPONG_EN undefined: WALK wraps N-1 -> 0. The direction flop is not instantiated.
- IDLE/JUMP/LAND are unaffected either way.

Decomposition:
- Package anim_pkg holds the anim_state_t enum (IDLE/WALK/JUMP/LAND, 2-bit) and the localparam bases IDLE_BASE=0, WALK_BASE=2048, JUMP_BASE=8192, LAND_BASE=12288.
- One natural sub-module, anim_prescaler: tick_in divider with synchronous clear, output adv pulse.
- The FSM, frame counter and address mux stay in the top.

Test Plan (default parameters):
- Reset asserted mid-WALK (frame_idx=3): outputs immediately IDLE/0/facing_left=0/sprite_addr=0. After release, 4 ticks give frame_idx=1 and sprite_addr=1024.
- move_right held, 24 ticks: WALK next cycle, frame_idx sequence 0..5,0, sprite_addr at frame 5 = 2048+5120=7168, facing_left=0.
- jump_req pulse in WALK, then 16 ticks: JUMP frames 0..3. Then 8 more ticks give LAND then IDLE, with jump_done high exactly 1 cycle and jump_busy high throughout.
- move_left+move_right both held: stays IDLE and facing unchanged. move_left alone -> WALK, facing_left=1. Holding right during JUMP keeps facing_left=1.
- tick_in on the same cycle as a move_right rise: WALK with frame_idx=0, prescaler=0. The next advance needs 4 further ticks.
- ANIM_PINGPONG_EN build, move_right held 44 ticks: frame_idx sequence 0,1,2,3,4,5,4,3,2,1,0,1.

Source files
------------

// File: rtl/anim_pkg.sv
// Shared types and sprite ROM base addresses for the animation frame sequencer.
// Each state's frames sit in a contiguous block of the sprite ROM that starts at its base.
package anim_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WALK = 2'd1,
      JUMP = 2'd2,
      LAND = 2'd3
   } anim_state_t;

   localparam int IDLE_BASE = 0;
   localparam int WALK_BASE = 2048;
   localparam int JUMP_BASE = 8192;
   localparam int LAND_BASE = 12288;

   function automatic int stateBase(input anim_state_t s);
      case (s)
         WALK:    return WALK_BASE;
         JUMP:    return JUMP_BASE;
         LAND:    return LAND_BASE;
         default: return IDLE_BASE;
      endcase
   endfunction

endpackage

// File: rtl/anim_prescaler.sv
// Divides the upstream tick_i pulses by TICKS_PER_FRAME and emits a one-cycle adv_o pulse.
// A synchronous clear returns the count to 0 so that a new state always starts a fresh frame period.
module anim_prescaler #(
   parameter int TICKS_PER_FRAME = 4
) (
   input  logic Clk,
   input  logic Reset,
   input  logic clear_i,
   input  logic tick_i,
   output logic adv_o
);
   import anim_pkg::*;

   localparam int CW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
   localparam logic [CW-1:0] LastCount = CW'(TICKS_PER_FRAME - 1);

   logic [CW-1:0] count_q, count_d;

   assign adv_o = tick_i && (count_q == LastCount);

   // Clear outranks ticking, so a tick on the cycle of a state change is discarded.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (tick_i) begin
         count_d = adv_o ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/anim_frame_sequencer.sv
// Player sprite animation sequencer: IDLE/WALK loops and a non-interruptible JUMP->LAND one-shot.
// Optional build macro ANIM_PINGPONG_EN makes the WALK loop play forwards then backwards.
module anim_frame_sequencer #(
   parameter int TICKS_PER_FRAME = 4,
   parameter int IDLE_FRAMES     = 2,
   parameter int WALK_FRAMES     = 6,
   parameter int JUMP_FRAMES     = 4,
   parameter int LAND_HOLD       = 2,
   parameter int FRAME_WORDS     = 1024,
   parameter int ADDR_W          = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              tick_in,
   input  logic              move_left,
   input  logic              move_right,
   input  logic              jump_req,
   output logic [1:0]        anim_state,
   output logic [2:0]        frame_idx,
   output logic              facing_left,
   output logic [ADDR_W-1:0] sprite_addr,
   output logic              jump_busy,
   output logic              jump_done
);
   import anim_pkg::*;

   localparam int LW = (LAND_HOLD > 1) ? $clog2(LAND_HOLD) : 1;
   localparam logic [2:0]    IdleLast = 3'(IDLE_FRAMES - 1);
   localparam logic [2:0]    WalkLast = 3'(WALK_FRAMES - 1);
   localparam logic [2:0]    JumpLast = 3'(JUMP_FRAMES - 1);
   localparam logic [LW-1:0] LandLast = LW'(LAND_HOLD - 1);

   anim_state_t   state_q, state_d;
   logic [2:0]    frameIdx_q, frameIdx_d;
   logic [LW-1:0] landCnt_q, landCnt_d;
   logic          facing_q, facing_d;
   logic          jumpDone_q, jumpDone_d;
   logic          walk;
   logic          adv;
   logic          stateChange;

`ifdef ANIM_PINGPONG_EN
   logic dirDown_q, dirDown_d;
`endif

   assign walk = move_left ^ move_right;

   anim_prescaler #(
      .TICKS_PER_FRAME(TICKS_PER_FRAME)
   ) uPrescaler (
      .Clk    (Clk),
      .Reset  (Reset),
      .clear_i(stateChange),
      .tick_i (tick_in),
      .adv_o  (adv)
   );

   // Next state first; any change then restarts the frame counter, LAND hold count and prescaler.
   always_comb begin
      state_d     = state_q;
      frameIdx_d  = frameIdx_q;
      landCnt_d   = landCnt_q;
      facing_d    = facing_q;
      jumpDone_d  = 1'b0;
`ifdef ANIM_PINGPONG_EN
      dirDown_d   = dirDown_q;
`endif

      case (state_q)
         IDLE: begin
            if (jump_req)  state_d = JUMP;
            else if (walk) state_d = WALK;
         end
         WALK: begin
            if (jump_req)   state_d = JUMP;
            else if (!walk) state_d = IDLE;
         end
         JUMP: begin
            if (adv && frameIdx_q == JumpLast) state_d = LAND;
         end
         LAND: begin
            if (adv && landCnt_q == LandLast) begin
               state_d    = walk ? WALK : IDLE;
               jumpDone_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      stateChange = (state_d != state_q);

      if (stateChange) begin
         frameIdx_d = '0;
         landCnt_d  = '0;
`ifdef ANIM_PINGPONG_EN
         dirDown_d  = 1'b0;
`endif
      end else if (adv) begin
         case (state_q)
            IDLE: frameIdx_d = (frameIdx_q == IdleLast) ? 3'd0 : frameIdx_q + 3'd1;
            WALK: begin
`ifdef ANIM_PINGPONG_EN
               if (!dirDown_q) begin
                  if (frameIdx_q == WalkLast) begin
                     frameIdx_d = WalkLast - 3'd1;
                     dirDown_d  = 1'b1;
                  end else begin
                     frameIdx_d = frameIdx_q + 3'd1;
                  end
               end else begin
                  if (frameIdx_q == 3'd0) begin
                     frameIdx_d = 3'd1;
                     dirDown_d  = 1'b0;
                  end else begin
                     frameIdx_d = frameIdx_q - 3'd1;
                  end
               end
`else
               frameIdx_d = (frameIdx_q == WalkLast) ? 3'd0 : frameIdx_q + 3'd1;
`endif
            end
            JUMP:    frameIdx_d = frameIdx_q + 3'd1;
            LAND:    landCnt_d  = landCnt_q + 1'b1;
            default: frameIdx_d = frameIdx_q;
         endcase
      end

      // Facing follows the held direction only while the player is on the ground and steering.
      if ((state_q == IDLE || state_q == WALK) && walk) begin
         facing_d = move_left;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= IDLE;
         frameIdx_q <= '0;
         landCnt_q  <= '0;
         facing_q   <= 1'b0;
         jumpDone_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         frameIdx_q <= frameIdx_d;
         landCnt_q  <= landCnt_d;
         facing_q   <= facing_d;
         jumpDone_q <= jumpDone_d;
      end
   end

`ifdef ANIM_PINGPONG_EN
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         dirDown_q <= 1'b0;
      end else begin
         dirDown_q <= dirDown_d;
      end
   end
`endif

   assign anim_state  = state_q;
   assign frame_idx   = frameIdx_q;
   assign facing_left = facing_q;
   assign jump_busy   = (state_q == JUMP) || (state_q == LAND);
   assign jump_done   = jumpDone_q;
   assign sprite_addr = ADDR_W'(stateBase(state_q) + int'(frameIdx_q) * FRAME_WORDS);

endmodule

// File: tb/tb_anim_frame_sequencer.sv
// Directed self-checking bench for anim_frame_sequencer at default parameters.
// Define ANIM_PINGPONG_EN for both RTL and bench to check the ping-pong WALK order.
module tb_anim_frame_sequencer;

   logic        Clk;
   logic        Reset;
   logic        tick_in;
   logic        move_left;
   logic        move_right;
   logic        jump_req;
   logic [1:0]  anim_state;
   logic [2:0]  frame_idx;
   logic        facing_left;
   logic [15:0] sprite_addr;
   logic        jump_busy;
   logic        jump_done;

   int assertCount;
   int failCount;

`ifdef ANIM_PINGPONG_EN
   localparam int WalkGroups = 11;
   int walkExp[WalkGroups] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
`else
   localparam int WalkGroups = 6;
   int walkExp[WalkGroups] = '{1, 2, 3, 4, 5, 0};
`endif

   anim_frame_sequencer uDut (
      .Clk        (Clk),
      .Reset      (Reset),
      .tick_in    (tick_in),
      .move_left  (move_left),
      .move_right (move_right),
      .jump_req   (jump_req),
      .anim_state (anim_state),
      .frame_idx  (frame_idx),
      .facing_left(facing_left),
      .sprite_addr(sprite_addr),
      .jump_busy  (jump_busy),
      .jump_done  (jump_done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic doCycle();
      @(posedge Clk);
      #1;
   endtask

   // Each tick is a one-cycle pulse followed by one quiet cycle.
   task automatic applyStimulus(input int nTicks);
      for (int i = 0; i < nTicks; i++) begin
         tick_in = 1'b1;
         doCycle();
         tick_in = 1'b0;
         doCycle();
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      Reset      = 1'b1;
      tick_in    = 1'b0;
      move_left  = 1'b0;
      move_right = 1'b0;
      jump_req   = 1'b0;
      doCycle();
      doCycle();

      // Reset state
      checkOutput("rst_state", 32'(anim_state), 0);
      checkOutput("rst_frame", 32'(frame_idx), 0);
      checkOutput("rst_facing", 32'(facing_left), 0);
      checkOutput("rst_addr", 32'(sprite_addr), 0);
      checkOutput("rst_busy", 32'(jump_busy), 0);
      checkOutput("rst_done", 32'(jump_done), 0);
      Reset = 1'b0;
      doCycle();

      // Walk right through the loop
      move_right = 1'b1;
      doCycle();
      checkOutput("walk_enter_state", 32'(anim_state), 1);
      checkOutput("walk_enter_frame", 32'(frame_idx), 0);
      checkOutput("walk_enter_addr", 32'(sprite_addr), 2048);
      for (int k = 0; k < WalkGroups; k++) begin
         applyStimulus(4);
         checkOutput("walk_frame", 32'(frame_idx), 32'(walkExp[k]));
         checkOutput("walk_addr", 32'(sprite_addr), 32'(2048 + walkExp[k] * 1024));
      end
      checkOutput("walk_facing", 32'(facing_left), 0);

      // Jump out of WALK, releasing movement on the same cycle
      jump_req   = 1'b1;
      move_right = 1'b0;
      doCycle();
      jump_req = 1'b0;
      checkOutput("jump_state", 32'(anim_state), 2);
      checkOutput("jump_busy0", 32'(jump_busy), 1);
      checkOutput("jump_addr0", 32'(sprite_addr), 8192);
      applyStimulus(12);
      checkOutput("jump_frame3", 32'(frame_idx), 3);
      checkOutput("jump_addr3", 32'(sprite_addr), 11264);
      applyStimulus(4);
      checkOutput("land_state", 32'(anim_state), 3);
      checkOutput("land_frame", 32'(frame_idx), 0);
      checkOutput("land_addr", 32'(sprite_addr), 12288);
      checkOutput("land_busy", 32'(jump_busy), 1);
      checkOutput("land_done", 32'(jump_done), 0);
      applyStimulus(7);
      checkOutput("land_hold_state", 32'(anim_state), 3);
      checkOutput("land_hold_busy", 32'(jump_busy), 1);
      tick_in = 1'b1;
      doCycle();
      tick_in = 1'b0;
      checkOutput("release_state", 32'(anim_state), 0);
      checkOutput("release_done", 32'(jump_done), 1);
      checkOutput("release_busy", 32'(jump_busy), 0);
      doCycle();
      checkOutput("release_done_end", 32'(jump_done), 0);

      // Both directions held means no walk and no facing change
      move_left  = 1'b1;
      move_right = 1'b1;
      doCycle();
      doCycle();
      checkOutput("both_state", 32'(anim_state), 0);
      checkOutput("both_facing", 32'(facing_left), 0);
      move_right = 1'b0;
      doCycle();
      checkOutput("left_state", 32'(anim_state), 1);
      checkOutput("left_facing", 32'(facing_left), 1);

      // Facing holds through a jump while the opposite direction is held
      jump_req = 1'b1;
      doCycle();
      jump_req   = 1'b0;
      move_left  = 1'b0;
      move_right = 1'b1;
      doCycle();
      checkOutput("jump2_state", 32'(anim_state), 2);
      checkOutput("jump2_facing", 32'(facing_left), 1);
      applyStimulus(16);
      checkOutput("land2_facing", 32'(facing_left), 1);
      applyStimulus(8);
      checkOutput("land2_exit_state", 32'(anim_state), 1);
      checkOutput("land2_exit_frame", 32'(frame_idx), 0);
      checkOutput("land2_exit_facing", 32'(facing_left), 0);

      // Tick coinciding with a state change is discarded and the prescaler restarts
      move_right = 1'b0;
      doCycle();
      checkOutput("stop_state", 32'(anim_state), 0);
      applyStimulus(2);
      move_left = 1'b1;
      tick_in   = 1'b1;
      doCycle();
      tick_in = 1'b0;
      checkOutput("coinc_state", 32'(anim_state), 1);
      checkOutput("coinc_frame", 32'(frame_idx), 0);
      applyStimulus(3);
      checkOutput("coinc_frame_3ticks", 32'(frame_idx), 0);
      applyStimulus(1);
      checkOutput("coinc_frame_4ticks", 32'(frame_idx), 1);
      checkOutput("coinc_addr", 32'(sprite_addr), 3072);

      // Asynchronous reset mid-WALK
      applyStimulus(8);
      checkOutput("prereset_frame", 32'(frame_idx), 3);
      checkOutput("prereset_facing", 32'(facing_left), 1);
      Reset = 1'b1;
      #1;
      checkOutput("async_state", 32'(anim_state), 0);
      checkOutput("async_frame", 32'(frame_idx), 0);
      checkOutput("async_facing", 32'(facing_left), 0);
      checkOutput("async_addr", 32'(sprite_addr), 0);
      move_left = 1'b0;
      doCycle();
      Reset = 1'b0;
      doCycle();
      applyStimulus(4);
      checkOutput("idle_frame1", 32'(frame_idx), 1);
      checkOutput("idle_addr1", 32'(sprite_addr), 1024);
      applyStimulus(4);
      checkOutput("idle_wrap", 32'(frame_idx), 0);

      // Reset during a jump aborts it without a done pulse
      jump_req = 1'b1;
      doCycle();
      jump_req = 1'b0;
      applyStimulus(5);
      checkOutput("abort_pre_frame", 32'(frame_idx), 1);
      Reset = 1'b1;
      #1;
      checkOutput("abort_state", 32'(anim_state), 0);
      checkOutput("abort_busy", 32'(jump_busy), 0);
      checkOutput("abort_done", 32'(jump_done), 0);
      doCycle();
      Reset = 1'b0;
      doCycle();
      doCycle();
      checkOutput("abort_done_after", 32'(jump_done), 0);
      checkOutput("abort_state_after", 32'(anim_state), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
